// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, default byte width
// and parity-type constants.
package uart_pkg;

  localparam int DEF_DATA_W = 8;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_WAIT_START = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE  = 2'd2;

  typedef enum logic [1:0] {
    IDLE       = ST_IDLE,
    WAIT_START = ST_WAIT_START,
    WAIT_DONE  = ST_WAIT_DONE
  } arb_state_e;

endpackage

// File: rtl/uart_rr_picker.sv
// Combinational round-robin pick: first asserted request at or above rr_ptr,
// wrapping around.
module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic [ID_W:0] idx;

  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      idx = {1'b0, rr_ptr} + (ID_W+1)'(off);
      if (idx >= (ID_W+1)'(NUM_REQ)) idx = idx - (ID_W+1)'(NUM_REQ);
      if (!any_req && req_valid[idx[ID_W-1:0]]) begin
        any_req = 1'b1;
        winner  = idx[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_REQ byte sources;
// issues a one-cycle start strobe and tracks tx_busy until the frame ends.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int START_TMO = 4,
  localparam int ID_W = $clog2(NUM_REQ)
) (
  input  logic                      clk_arb,
  input  logic                      rst_arb,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        cfg_par_en,
  input  logic [NUM_REQ-1:0]        cfg_par_typ,
  output logic [NUM_REQ-1:0]        req_ack,
  input  logic                      tx_busy,
  output logic [DATA_W-1:0]         tx_data,
  output logic                      tx_data_valid,
  output logic                      tx_par_en,
  output logic                      tx_par_typ,
  output logic [ID_W-1:0]           grant_id,
  output logic                      arb_busy,
  output logic                      err_start
);

  localparam int CNT_W = $clog2(START_TMO + 1);

  arb_state_e                       state, state_nx;
  logic [CNT_W-1:0]                 cnt, cnt_nx;
  logic [ID_W-1:0]                  rr_ptr, rr_nx;
  logic [ID_W-1:0]                  winner;
  logic                             any_req;
  logic [NUM_REQ-1:0][DATA_W-1:0]   req_bytes;

  logic [DATA_W-1:0]  data_nx;
  logic               dv_nx, pe_nx, pt_nx, err_nx;
  logic [NUM_REQ-1:0] ack_nx;
  logic [ID_W-1:0]    gid_nx;

  assign req_bytes = req_data;

  uart_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .winner    (winner),
    .any_req   (any_req)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rr_nx    = rr_ptr;
    data_nx  = tx_data;
    pe_nx    = tx_par_en;
    pt_nx    = tx_par_typ;
    gid_nx   = grant_id;
    dv_nx    = 1'b0;
    ack_nx   = '0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        // Never strobe into a transmitter that still reports busy.
        if (any_req && !tx_busy) begin
          state_nx       = WAIT_START;
          cnt_nx         = '0;
          data_nx        = req_bytes[winner];
          pe_nx          = cfg_par_en[winner];
          pt_nx          = cfg_par_typ[winner];
          gid_nx         = winner;
          dv_nx          = 1'b1;
          ack_nx[winner] = 1'b1;
          rr_nx          = (winner == ID_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
        end
      end
      WAIT_START: begin
        if (tx_busy) begin
          state_nx = WAIT_DONE;
        end else if (cnt == CNT_W'(START_TMO-1)) begin
          // Byte was already acked; it is dropped, not retried.
          state_nx = IDLE;
          err_nx   = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_arb or negedge rst_arb) begin
    if (!rst_arb) begin
      state         <= IDLE;
      cnt           <= '0;
      rr_ptr        <= '0;
      tx_data       <= '0;
      tx_data_valid <= 1'b0;
      tx_par_en     <= 1'b0;
      tx_par_typ    <= PAR_EVEN;
      req_ack       <= '0;
      grant_id      <= '0;
      arb_busy      <= 1'b0;
      err_start     <= 1'b0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      rr_ptr        <= rr_nx;
      tx_data       <= data_nx;
      tx_data_valid <= dv_nx;
      tx_par_en     <= pe_nx;
      tx_par_typ    <= pt_nx;
      req_ack       <= ack_nx;
      grant_id      <= gid_nx;
      arb_busy      <= (state_nx != IDLE);
      err_start     <= err_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: per-requester byte queues, a simple
// TX busy model, and expected grants queued as stimulus is loaded.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int BUSY_LEN = 11;

  logic        clk_arb = 1'b0;
  logic        rst_arb = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  cfg_par_en = '0;
  logic [3:0]  cfg_par_typ = '0;
  logic [3:0]  req_ack;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_data_valid, tx_par_en, tx_par_typ;
  logic [1:0]  grant_id;
  logic        arb_busy, err_start;

  uart_tx_arbiter dut (
    .clk_arb(clk_arb), .rst_arb(rst_arb), .req_valid(req_valid), .req_data(req_data),
    .cfg_par_en(cfg_par_en), .cfg_par_typ(cfg_par_typ), .req_ack(req_ack),
    .tx_busy(tx_busy), .tx_data(tx_data), .tx_data_valid(tx_data_valid),
    .tx_par_en(tx_par_en), .tx_par_typ(tx_par_typ), .grant_id(grant_id),
    .arb_busy(arb_busy), .err_start(err_start)
  );

  always #5 clk_arb = ~clk_arb;

  // TX model: busy rises the cycle after the strobe and lasts BUSY_LEN cycles.
  int busy_cnt;
  bit no_busy = 1'b0;
  always @(posedge clk_arb or negedge rst_arb) begin
    if (!rst_arb) busy_cnt <= 0;
    else if (tx_data_valid && !no_busy) busy_cnt <= BUSY_LEN;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0);

  typedef struct {
    int         id;
    logic [7:0] data;
    logic       pe;
    logic       pt;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] bq[4][$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, last_strobe = 0, strobes = 0, errs = 0, busy_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < 4; i++) begin
      req_valid[i] = (bq[i].size() != 0);
      if (bq[i].size() != 0) req_data[i*8 +: 8] = bq[i][0];
    end
  endtask

  task automatic load(input int id, input logic [7:0] d);
    bq[id].push_back(d);
    refresh();
  endtask

  task automatic expect_grant(input int id, input logic [7:0] d, input logic pe, input logic pt);
    exp_t e;
    e.id = id; e.data = d; e.pe = pe; e.pt = pt;
    sb.push_back(e);
  endtask

  // One cycle: sample at negedge, score strobes/errors, retire acked bytes.
  task automatic tick();
    exp_t e;
    @(negedge clk_arb);
    cyc++;
    if (tx_data_valid) begin
      strobes++;
      last_strobe = cyc;
      chk("busy_at_strobe", 32'(tx_busy), 32'(0));
      if (sb.size() == 0) chk("unexpected_strobe", 32'(1), 32'(0));
      else begin
        e = sb.pop_front();
        chk("grant_id", 32'(grant_id), 32'(e.id));
        chk("tx_data", 32'(tx_data), 32'(e.data));
        chk("tx_par_en", 32'(tx_par_en), 32'(e.pe));
        chk("tx_par_typ", 32'(tx_par_typ), 32'(e.pt));
        chk("req_ack", 32'(req_ack), 32'(1) << e.id);
      end
    end else if (req_ack != 0) begin
      chk("ack_without_strobe", 32'(req_ack), 32'(0));
    end
    if (err_start) begin
      errs++;
      chk("err_delay", 32'(cyc - last_strobe), 32'(4));
      chk("err_arb_busy", 32'(arb_busy), 32'(0));
    end
    if (arb_busy) busy_cyc++;
    for (int i = 0; i < 4; i++)
      if (req_ack[i] && bq[i].size() != 0) void'(bq[i].pop_front());
    refresh();
  endtask

  function automatic bit all_idle();
    bit q_empty = 1'b1;
    for (int i = 0; i < 4; i++) if (bq[i].size() != 0) q_empty = 1'b0;
    return q_empty && sb.size() == 0 && !arb_busy && !tx_busy;
  endfunction

  task automatic wait_idle(input string tag);
    int n = 0;
    do begin tick(); n++; end while (!all_idle() && n < 400);
    if (!all_idle()) chk({tag, "_idle_timeout"}, 32'(0), 32'(1));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_tx_data"}, 32'(tx_data), 32'(0));
    chk({tag, "_tx_data_valid"}, 32'(tx_data_valid), 32'(0));
    chk({tag, "_tx_par_en"}, 32'(tx_par_en), 32'(0));
    chk({tag, "_tx_par_typ"}, 32'(tx_par_typ), 32'(PAR_EVEN));
    chk({tag, "_req_ack"}, 32'(req_ack), 32'(0));
    chk({tag, "_grant_id"}, 32'(grant_id), 32'(0));
    chk({tag, "_arb_busy"}, 32'(arb_busy), 32'(0));
    chk({tag, "_err_start"}, 32'(err_start), 32'(0));
  endtask

  initial begin
    int s0, b0, e0, n;
    #1 rst_arb = 1'b0;
    #1 chk_outputs_zero("reset");
    repeat (3) tick();
    rst_arb = 1'b1;
    tick();

    // All four pending: strict rotation from rr_ptr=0, requester 0 re-requests.
    load(0, 8'h10); load(0, 8'h10); load(1, 8'h11); load(2, 8'h12); load(3, 8'h13);
    expect_grant(0, 8'h10, 0, 0); expect_grant(1, 8'h11, 0, 0);
    expect_grant(2, 8'h12, 0, 0); expect_grant(3, 8'h13, 0, 0);
    expect_grant(0, 8'h10, 0, 0);
    wait_idle("rotate");

    // Grant 1 moves the pointer to 2; then 0 and 3 together -> 3 first.
    load(1, 8'h21); expect_grant(1, 8'h21, 0, 0);
    wait_idle("rr_setup");
    load(0, 8'h30); load(3, 8'h33);
    expect_grant(3, 8'h33, 0, 0); expect_grant(0, 8'h30, 0, 0);
    wait_idle("rr_wrap");

    // Single requester 2: one strobe, arb_busy for 13 cycles.
    s0 = strobes; b0 = busy_cyc; e0 = errs;
    load(2, 8'hA5); expect_grant(2, 8'hA5, 0, 0);
    wait_idle("single");
    chk("single_strobes", 32'(strobes - s0), 32'(1));
    chk("single_busy_cycles", 32'(busy_cyc - b0), 32'(13));
    chk("single_no_err", 32'(errs - e0), 32'(0));

    // Parity config follows the granted requester and holds until next grant.
    cfg_par_en = 4'b0010; cfg_par_typ = 4'b0010;
    load(1, 8'h3C); expect_grant(1, 8'h3C, 1, PAR_ODD);
    n = 0;
    do begin tick(); n++; end while (!tx_busy && n < 20);
    repeat (4) tick();
    chk("par_en_hold_busy", 32'(tx_par_en), 32'(1));
    chk("par_typ_hold_busy", 32'(tx_par_typ), 32'(1));
    wait_idle("parity1");
    chk("par_en_hold_idle", 32'(tx_par_en), 32'(1));
    chk("par_typ_hold_idle", 32'(tx_par_typ), 32'(1));
    load(0, 8'h4D); expect_grant(0, 8'h4D, 0, PAR_EVEN);
    wait_idle("parity0");
    chk("par_en_cleared", 32'(tx_par_en), 32'(0));
    chk("par_typ_cleared", 32'(tx_par_typ), 32'(0));
    cfg_par_en = '0; cfg_par_typ = '0;

    // Start timeout: TX never goes busy; both pending bytes time out in turn.
    no_busy = 1'b1;
    s0 = strobes; e0 = errs;
    load(2, 8'h55); load(3, 8'h66);
    expect_grant(2, 8'h55, 0, 0); expect_grant(3, 8'h66, 0, 0);
    wait_idle("timeout");
    chk("timeout_strobes", 32'(strobes - s0), 32'(2));
    chk("timeout_errs", 32'(errs - e0), 32'(2));
    no_busy = 1'b0;

    // Reset mid-frame with 1 and 3 pending; pointer must restart at 0.
    load(1, 8'h81); expect_grant(1, 8'h81, 0, 0);
    n = 0;
    do begin tick(); n++; end while (!tx_busy && n < 20);
    repeat (3) tick();
    chk("pre_reset_busy", 32'(arb_busy), 32'(1));
    load(1, 8'h91); load(3, 8'h93);
    #2 rst_arb = 1'b0;
    #1 chk_outputs_zero("async_reset");
    sb.delete();
    repeat (2) tick();
    rst_arb = 1'b1;
    expect_grant(1, 8'h91, 0, 0); expect_grant(3, 8'h93, 0, 0);
    wait_idle("post_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one UART transmitter (serializer, parity unit, mux and TX FSM) among `NUM_REQ` byte requesters. It grants one requester at a time and issues a single-cycle `data_valid` strobe with that requester's byte and parity configuration. It then tracks the transmitter's `busy` output until the frame completes. It sits between the system-side byte sources and the UART TX top.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `DATA_W`, default 8: byte width.
- `START_TMO`, default 4: cycles allowed for `tx_busy` to rise after the strobe.
- `clk_arb`  in  1  clock.
- `rst_arb`  in  1  reset; asynchronous, active-low.
- `req_valid`  in  NUM_REQ  per-requester "byte pending", level.
- `req_data`  in  NUM_REQ*DATA_W  requester i's byte at `[i*DATA_W +: DATA_W]`.
- `cfg_par_en`  in  NUM_REQ  per-requester parity enable, quasi-static.
- `cfg_par_typ`  in  NUM_REQ  per-requester parity type (0 even, 1 odd), quasi-static.
- `req_ack`  out  NUM_REQ  one-cycle pulse; the byte of requester i has been captured.
- `tx_busy`  in  1  busy from the UART TX.
- `tx_data`  out  DATA_W  byte to the UART TX.
- `tx_data_valid`  out  1  one-cycle start strobe to the UART TX.
- `tx_par_en`  out  1  parity enable to the UART TX.
- `tx_par_typ`  out  1  parity type to the UART TX.
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last granted requester.
- `arb_busy`  out  1  high in any state other than IDLE.
- `err_start`  out  1  one-cycle pulse on start timeout.

## Operation
- States: IDLE, WAIT_START, WAIT_DONE. All outputs are registered.
- Round-robin pointer `rr_ptr`:
  - Winner is the first asserted `req_valid`, searching upward from `rr_ptr` with wrap-around.
  - At grant, `rr_ptr <= winner+1`, wrapping modulo `NUM_REQ`.
- IDLE → WAIT_START: requires any `req_valid` and `tx_busy==0`. On that edge:
  - Capture `req_data[winner]` into `tx_data`.
  - Capture `cfg_par_en[winner]` and `cfg_par_typ[winner]` into `tx_par_en` and `tx_par_typ`.
  - Set `grant_id = winner`.
  - Assert `tx_data_valid` and `req_ack[winner]`.
  - Clear the timeout counter.
- IDLE with `tx_busy==1`: no grant; stay in IDLE.
- WAIT_START:
  - `tx_busy==1` → WAIT_DONE.
  - Otherwise the counter increments. When the counter reaches `START_TMO-1` with `tx_busy` still 0 → IDLE and pulse `err_start`.
  - On timeout the byte is dropped: it was already acked and is not retried.
- WAIT_DONE: `tx_busy==0` → IDLE.
- `tx_data`, `tx_par_en`, `tx_par_typ` and `grant_id` hold their values until the next grant.
- A requester must hold `req_valid` and data until it sees `req_ack`. It may deassert `req_valid` at any time; if it does before the grant edge, it is not granted.
- Simultaneous requests are resolved only by `rr_ptr`; there are no fixed priorities.

## Timing
- Reset (asynchronous, active-low) takes effect immediately, regardless of state:
  - State → IDLE, `rr_ptr=0`.
  - `tx_data=0`, `tx_data_valid=0`, `tx_par_en=0`, `tx_par_typ=0`.
  - `req_ack=0`, `grant_id=0`, `arb_busy=0`, `err_start=0`.
- A frame in flight when reset asserts is abandoned; the TX block is reset by the same net.
- Grant latency: `req_valid` sampled high in IDLE at edge k → `tx_data_valid` and `req_ack` high for the cycle after edge k, exactly one cycle.
- `tx_data` and parity outputs are valid in the same cycle as `tx_data_valid`.
- `arb_busy` rises together with `tx_data_valid`. It falls on the edge after `tx_busy` is sampled low in WAIT_DONE, or together with `err_start`.
- Minimum gap: a new grant can happen on the first IDLE edge where `tx_busy==0`. `tx_data_valid` is never asserted while `tx_busy==1`.
- Maximum throughput: one frame per (frame length + 2) cycles.

## Structure
- Shared package `uart_pkg`:
  - State encoding localparams for IDLE, WAIT_START and WAIT_DONE.
  - `DATA_W` default.
  - Parity-type constants `PAR_EVEN=0` and `PAR_ODD=1`.
- One sub-module, `uart_rr_picker`: combinational.
  - Inputs: `req_valid`, `rr_ptr`.
  - Outputs: `winner` index and `any_req`.
- The arbiter holds the FSM, the timeout counter and the output registers.

## Test plan
- Requester 2 alone with `req_data=0xA5`; the TX model raises busy one cycle after the strobe and holds it for 11 cycles → one `tx_data_valid` with `tx_data=0xA5`, one `req_ack[2]`, `grant_id=2`, `arb_busy` high for 13 cycles.
- All four `req_valid` held high, bytes 0x10/0x11/0x12/0x13 → grant order 0,1,2,3,0 and `tx_data` sequence 0x10,0x11,0x12,0x13,0x10; no strobe while `tx_busy=1`.
- `rr_ptr=2` (after a grant to requester 1), requests on 0 and 3 → grant 3, then 0.
- `START_TMO=4`, TX model never raises busy → `err_start` pulses once 4 cycles after the strobe and the arbiter returns to IDLE; the next pending request is granted with a fresh strobe.
- Requester 1 with `cfg_par_en=1` and `cfg_par_typ=1` → `tx_par_en=1` and `tx_par_typ=1` from the strobe until the next grant; a following requester 0 grant with `par_en=0` clears them.
- Reset asserted mid-WAIT_DONE with a request pending → all outputs 0 asynchronously; after release the pending requester wins, searching from `rr_ptr=0`.
